// File: rtl/alarm_pkg.sv
// Shared types and helpers for the alarm scheduler: data width, FSM states
// and the modular "already passed" test.
package alarm_pkg;

  localparam int ALARM_W = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ARMED = 2'd1,
    GUARD = 2'd2
  } alarm_state_e;

  // Head is late when (head - counter) is negative in modulo-2^32 arithmetic,
  // so times up to 2^31-1 ahead stay valid across the counter wrap.
  function automatic logic is_late(input logic [ALARM_W-1:0] head,
                                   input logic [ALARM_W-1:0] counter);
    logic [ALARM_W-1:0] diff;
    diff = head - counter;
    return diff[ALARM_W-1];
  endfunction

endpackage

// File: rtl/alarm_scheduler_if.sv
// Host/generator-facing signal bundle of the alarm scheduler. The scheduler
// takes the master side; host, counter and generator take the slave side.
interface alarm_scheduler_if
  import alarm_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) ();

  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic               push_valid_i;
  logic [ALARM_W-1:0] push_time_i;
  logic               push_ready_o;
  logic [ALARM_W-1:0] counter_i;
  logic               alarm_en_o;
  logic [ALARM_W-1:0] alarm_o;
  logic               alarm_hit_i;
  logic               irq_o;
  logic               irq_ack_i;
  logic               late_o;
  logic [CNT_W-1:0]   fired_cnt_o;
  logic [LVL_W-1:0]   level_o;

  modport master (
    input  push_valid_i, push_time_i, counter_i, alarm_hit_i, irq_ack_i,
    output push_ready_o, alarm_en_o, alarm_o, irq_o, late_o, fired_cnt_o, level_o
  );

  modport slave (
    output push_valid_i, push_time_i, counter_i, alarm_hit_i, irq_ack_i,
    input  push_ready_o, alarm_en_o, alarm_o, irq_o, late_o, fired_cnt_o, level_o
  );

endinterface

// File: rtl/alarm_fifo.sv
// DEPTH x ALARM_W synchronous FIFO with combinational head, level and
// full/empty flags; pushes when full and pops when empty are dropped.
module alarm_fifo
  import alarm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_an_i,
  input  logic                       rst_i,
  input  logic                       push,
  input  logic [ALARM_W-1:0]         push_data,
  input  logic                       pop,
  output logic [ALARM_W-1:0]         head,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [ALARM_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [LW-1:0]      count;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + LW'(do_push) - LW'(do_pop);
    end
  end

  // NOTE: storage is left unreset; stale entries are never observable because
  // the head is masked to zero whenever the queue is empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head  = empty ? '0 : mem[rd_ptr];
  assign level = count;

endmodule

// File: rtl/alarm_scheduler.sv
// Queues alarm times, arms the generator with the oldest one, retires it on a
// hit (irq + fired count) or when the counter has already passed it (late).
module alarm_scheduler
  import alarm_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_an_i,
  input  logic                rst_i,
  alarm_scheduler_if.master   bus
);

  localparam int LW = $clog2(DEPTH) + 1;

  alarm_state_e       state_q;
  alarm_state_e       state_d;
  logic [ALARM_W-1:0] head;
  logic [LW-1:0]      level;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push_acc;
  logic               hit;
  logic               late_drop;
  logic               pop;
  logic               irq_q;
  logic               late_q;
  logic [CNT_W-1:0]   fired_q;

  assign push_acc  = bus.push_valid_i && !fifo_full;
  // Hit wins over late: it lands one cycle after counter==head, when the
  // modular difference already reads -1.
  assign hit       = (state_q == ARMED) && bus.alarm_hit_i;
  assign late_drop = (state_q == ARMED) && !bus.alarm_hit_i && !fifo_empty
                     && is_late(head, bus.counter_i);
  assign pop       = hit || late_drop;

  alarm_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i     (clk_i),
    .rst_an_i  (rst_an_i),
    .rst_i     (rst_i),
    .push      (bus.push_valid_i),
    .push_data (bus.push_time_i),
    .pop       (pop),
    .head      (head),
    .level     (level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // NOTE: state_d gets a default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (push_acc) state_d = ARMED;
      ARMED:   if (pop)      state_d = GUARD;
      // One disarmed cycle flushes the generator's registered compare of the
      // retired head; a push landing here must still re-arm.
      GUARD:   state_d = (level != '0 || push_acc) ? ARMED : EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) begin
      state_q <= EMPTY;
      irq_q   <= 1'b0;
      late_q  <= 1'b0;
      fired_q <= '0;
    end else if (rst_i) begin
      state_q <= EMPTY;
      irq_q   <= 1'b0;
      late_q  <= 1'b0;
      fired_q <= '0;
    end else begin
      state_q <= state_d;
      if (hit)                  irq_q <= 1'b1;
      else if (bus.irq_ack_i)   irq_q <= 1'b0;
      if (hit && fired_q != '1) fired_q <= fired_q + CNT_W'(1);
      if (late_drop)            late_q <= 1'b1;
    end
  end

  assign bus.push_ready_o = !fifo_full;
  assign bus.alarm_en_o   = (state_q == ARMED);
  assign bus.alarm_o      = head;
  assign bus.irq_o        = irq_q;
  assign bus.late_o       = late_q;
  assign bus.fired_cnt_o  = fired_q;
  assign bus.level_o      = level;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic against a
// queue-based reference model with a modelled registered-compare generator.
module tb_alarm_scheduler;

  localparam int DEPTH     = 4;
  localparam int CNT_W     = 4;
  localparam int FIRED_MAX = (1 << CNT_W) - 1;

  logic clk    = 1'b0;
  logic rst_an = 1'b0;
  logic rst    = 1'b0;

  alarm_scheduler_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  alarm_scheduler #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i    (clk),
    .rst_an_i (rst_an),
    .rst_i    (rst),
    .bus      (bus.master)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: a plain queue plus armed/guard flags and status bits.
  logic [31:0] mq[$];
  bit          m_armed;
  bit          m_guard;
  bit          m_irq;
  bit          m_late;
  int          m_fired;
  bit          last_accept;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    mq.delete();
    m_armed = 1'b0;
    m_guard = 1'b0;
    m_irq   = 1'b0;
    m_late  = 1'b0;
    m_fired = 0;
  endfunction

  task automatic check_outputs();
    check("alarm_en",   32'(bus.alarm_en_o),   32'(m_armed));
    check("alarm",      bus.alarm_o,           (mq.size() > 0) ? mq[0] : 32'd0);
    check("push_ready", 32'(bus.push_ready_o), 32'(mq.size() < DEPTH));
    check("level",      32'(bus.level_o),      32'(mq.size()));
    check("irq",        32'(bus.irq_o),        32'(m_irq));
    check("late",       32'(bus.late_o),       32'(m_late));
    check("fired_cnt",  32'(bus.fired_cnt_o),  32'(m_fired));
  endtask

  // Called at a falling edge with this cycle's inputs applied; advances the
  // model, crosses one rising edge and checks at the next falling edge.
  task automatic cycle();
    logic [31:0] cnt;
    logic [31:0] diff;
    bit          hit;
    bit          gen_next;
    bit          pop_hit;
    bit          pop_late;
    cnt      = bus.counter_i;
    hit      = bus.alarm_hit_i;
    gen_next = m_armed && (mq.size() > 0) && (mq[0] == cnt);
    last_accept = 1'b0;
    if (rst) begin
      model_clear();
    end else begin
      last_accept = bus.push_valid_i && (mq.size() < DEPTH);
      pop_hit  = m_armed && hit;
      diff     = m_armed ? (mq[0] - cnt) : 32'd0;
      pop_late = m_armed && !hit && ($signed(diff) < 0);
      if (pop_hit) m_irq = 1'b1;
      else if (bus.irq_ack_i) m_irq = 1'b0;
      if (pop_hit && m_fired < FIRED_MAX) m_fired++;
      if (pop_late) m_late = 1'b1;
      if (pop_hit || pop_late) void'(mq.pop_front());
      if (last_accept) mq.push_back(bus.push_time_i);
      if (pop_hit || pop_late) begin
        m_guard = 1'b1;
        m_armed = 1'b0;
      end else if (m_guard) begin
        m_guard = 1'b0;
        m_armed = (mq.size() > 0);
      end else if (!m_armed) begin
        m_armed = (mq.size() > 0);
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    bus.alarm_hit_i = gen_next;
    bus.counter_i   = cnt + 32'd1;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic push(input logic [31:0] t);
    int waited = 0;
    bus.push_valid_i = 1'b1;
    bus.push_time_i  = t;
    do begin
      cycle();
      waited++;
    end while (!last_accept && waited < 100);
    bus.push_valid_i = 1'b0;
    if (!last_accept) check("push_timeout", 32'(last_accept), 32'd1);
  endtask

  task automatic clear_sync();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    bit seen;
    bus.push_valid_i = 1'b0;
    bus.push_time_i  = '0;
    bus.counter_i    = '0;
    bus.alarm_hit_i  = 1'b0;
    bus.irq_ack_i    = 1'b0;
    model_clear();
    #2 check_outputs();
    @(negedge clk);
    rst_an = 1'b1;

    // Single alarm: armed next cycle, hit at counter 0x11, back to idle.
    clear_sync();
    bus.counter_i = 32'h0;
    push(32'h10);
    check("t1_armed", 32'(bus.alarm_en_o), 32'd1);
    run(20);
    check("t1_irq",   32'(bus.irq_o),       32'd1);
    check("t1_fired", 32'(bus.fired_cnt_o), 32'd1);
    check("t1_level", 32'(bus.level_o),     32'd0);
    check("t1_en",    32'(bus.alarm_en_o),  32'd0);

    // Fill the queue, fifth push waits for the first retirement.
    clear_sync();
    bus.counter_i = 32'h18;
    push(32'h20);
    push(32'h30);
    push(32'h40);
    push(32'h50);
    check("t2_full_ready", 32'(bus.push_ready_o), 32'd0);
    check("t2_full_level", 32'(bus.level_o),      32'd4);
    push(32'h60);
    run(80);
    check("t2_fired", 32'(bus.fired_cnt_o), 32'd5);
    check("t2_level", 32'(bus.level_o),     32'd0);

    // Already-passed time is dropped and flagged late.
    clear_sync();
    bus.counter_i = 32'h100;
    push(32'h05);
    run(1);
    check("t3_late",  32'(bus.late_o),      32'd1);
    check("t3_irq",   32'(bus.irq_o),       32'd0);
    check("t3_fired", 32'(bus.fired_cnt_o), 32'd0);
    check("t3_level", 32'(bus.level_o),     32'd0);

    // Alarm across the 32-bit wrap is not late.
    clear_sync();
    bus.counter_i = 32'hFFFF_FFF0;
    push(32'h4);
    run(30);
    check("t4_irq",  32'(bus.irq_o),  32'd1);
    check("t4_late", 32'(bus.late_o), 32'd0);

    // Ack coinciding with a second hit loses; a lone ack clears.
    clear_sync();
    bus.counter_i = 32'h200;
    push(32'h208);
    push(32'h210);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (m_irq && bus.alarm_hit_i) begin
        bus.irq_ack_i = 1'b1;
        cycle();
        bus.irq_ack_i = 1'b0;
        check("t5_set_wins", 32'(bus.irq_o), 32'd1);
        seen = 1'b1;
      end else begin
        cycle();
      end
    end
    check("t5_second_hit", 32'(seen), 32'd1);
    bus.irq_ack_i = 1'b1;
    cycle();
    bus.irq_ack_i = 1'b0;
    check("t5_ack_clears", 32'(bus.irq_o),       32'd0);
    check("t5_fired",      32'(bus.fired_cnt_o), 32'd2);

    // Synchronous clear with entries pending.
    clear_sync();
    bus.counter_i = 32'h300;
    push(32'h340);
    push(32'h350);
    push(32'h360);
    run(5);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("t6_level", 32'(bus.level_o),     32'd0);
    check("t6_en",    32'(bus.alarm_en_o),  32'd0);
    check("t6_late",  32'(bus.late_o),      32'd0);
    check("t6_fired", 32'(bus.fired_cnt_o), 32'd0);
    run(120);
    check("t6_no_irq", 32'(bus.irq_o), 32'd0);

    // Asynchronous reset between edges takes effect immediately.
    push(bus.counter_i + 32'h40);
    push(bus.counter_i + 32'h50);
    push(bus.counter_i + 32'h60);
    run(5);
    #2 rst_an = 1'b0;
    #1;
    model_clear();
    check("t7_level", 32'(bus.level_o),     32'd0);
    check("t7_en",    32'(bus.alarm_en_o),  32'd0);
    check("t7_alarm", bus.alarm_o,          32'd0);
    check("t7_ready", 32'(bus.push_ready_o), 32'd1);
    bus.alarm_hit_i = 1'b0;
    @(negedge clk);
    rst_an = 1'b1;
    run(120);
    check("t7_no_irq", 32'(bus.irq_o), 32'd0);

    // Random traffic: near/late times, acks, spurious hits, jumps, clears.
    clear_sync();
    for (int i = 0; i < 1500; i++) begin
      bus.push_valid_i = ($urandom_range(0, 2) == 0);
      bus.push_time_i  = bus.counter_i + 32'($urandom_range(0, 40)) - 32'd6;
      bus.irq_ack_i    = ($urandom_range(0, 7) == 0);
      rst              = ($urandom_range(0, 599) == 0);
      if (!m_armed && $urandom_range(0, 9) == 0) bus.alarm_hit_i = 1'b1;
      if ($urandom_range(0, 99) == 0) bus.counter_i = bus.counter_i + 32'($urandom_range(0, 1000));
      cycle();
    end
    bus.push_valid_i = 1'b0;
    bus.irq_ack_i    = 1'b0;
    rst              = 1'b0;
    run(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alarm_scheduler.md
Name: alarm_scheduler

Overview:
- Host-side companion that drives and consumes the alarm generator interface.
- Queues up to DEPTH programmed alarm times and presents the oldest one to the generator as compare value plus enable.
- Consumes the generator's one-cycle alarm pulse, retires the entry and raises a sticky interrupt.
- Detects alarm times the free-running counter has already passed, drops them and flags them as late.

Parameters:
DEPTH, 4, number of queued alarm entries (power of 2, min 2)
CNT_W, 16, width of fired-alarm counter

Ports:
clk_i  in  1  clock
rst_an_i  in  1  asynchronous active-low reset
rst_i  in  1  synchronous active-high clear
push_valid_i  in  1  host offers a new alarm time
push_time_i  in  32  alarm time to enqueue
push_ready_o  out  1  queue can accept (not full)
counter_i  in  32  free-running time counter, same value fed to the generator
alarm_en_o  out  1  enable to generator
alarm_o  out  32  compare value to generator (queue head)
alarm_hit_i  in  1  registered match pulse from generator
irq_o  out  1  alarm fired, level, held until acknowledged
irq_ack_i  in  1  clears irq_o
late_o  out  1  sticky: at least one entry dropped as already passed
fired_cnt_o  out  CNT_W  number of alarms fired, saturating
level_o  out  $clog2(DEPTH)+1  queue occupancy

Behaviour:
- Reset is rst_an_i, asynchronous, active-low; clock is clk_i.
- rst_i is a synchronous clear with identical effect to rst_an_i.
- Reset/clear values:
  - queue empty, state EMPTY;
  - alarm_en_o=0, alarm_o=0, irq_o=0, late_o=0, fired_cnt_o=0, level_o=0;
  - push_ready_o=1.
- Clear mid-operation discards all queued entries; no pulse or irq follows.
- Push:
  - Accepted on a clk_i edge with push_valid_i && push_ready_o.
  - push_ready_o = !full (combinational from level).
  - Accepts when full are impossible; push_valid_i held while full simply waits.
- alarm_o always equals the queue head (0 when empty).
- alarm_en_o = (state==ARMED), registered.
- State machine:
  - EMPTY: alarm_en_o=0. On accepted push -> ARMED next cycle.
  - ARMED: alarm_en_o=1.
    - If alarm_hit_i=1: pop head, irq_o<=1, fired_cnt_o+=1 (saturate at all-ones), -> GUARD.
    - Else if signed(alarm_o - counter_i) < 0 (modulo-2^32 difference, MSB set): pop head, late_o<=1, -> GUARD.
    - Else stay.
  - GUARD: one cycle, alarm_en_o=0, alarm_hit_i ignored. This flushes the generator's one-cycle registered compare so the old head cannot fire twice. Then -> ARMED if level after pop > 0, else EMPTY.
- Hit has priority over late: the hit arrives one cycle after counter==head, when the difference is already -1.
- Wrap-around:
  - The late check uses modular signed difference, so alarm times up to 2^31-1 ahead of the counter are valid across the 32-bit wrap.
  - Head == counter_i is not late.
- Simultaneous push and pop in the same cycle: both take effect and level_o is unchanged. A push into a queue that is not full is legal during a pop.
- irq_o:
  - Set on hit, cleared on irq_ack_i.
  - If a set and irq_ack_i occur in the same cycle, set wins.
  - Multiple hits before ack leave irq_o=1; fired_cnt_o counts each hit.
- late_o is cleared only by reset/clear.
- alarm_hit_i while EMPTY or GUARD: ignored, no state change.
- Latency:
  - Push into an empty queue -> alarm_en_o=1 one cycle later.
  - alarm_hit_i -> irq_o and pop visible the next cycle.

Decomposition:
- Package alarm_pkg: ALARM_W=32, state enum {EMPTY, ARMED, GUARD}, helper function is_late(head, counter) returning the modular-difference MSB.
- Sub-module alarm_fifo:
  - DEPTH x 32 synchronous FIFO with push/pop, level, full/empty.
  - Head value available combinationally.
  - Async reset on rst_an_i, sync clear on rst_i.
- The FSM and counters live in alarm_scheduler.

Test Plan:
- Push 0x00000010 while counter_i=0x00000000 incrementing -> alarm_en_o=1 next cycle; generator hit at counter 0x11; irq_o=1, fired_cnt_o=1, level_o=0, state EMPTY after GUARD.
- Push 0x20, 0x30, 0x40, 0x50 back-to-back -> push_ready_o=0 after the fourth push. A fifth push is held until the first hit, then accepted. Hits occur in order with one GUARD cycle each; fired_cnt_o=5 at end.
- Push 0x05 when counter_i=0x100 -> entry dropped in the first ARMED cycle, late_o=1, irq_o=0, fired_cnt_o=0.
- Counter at 0xFFFFFFF0, push 0x00000004 -> not late; hit when the counter wraps past 4; irq_o=1.
- irq_ack_i asserted in the same cycle as a second alarm_hit_i -> irq_o stays 1. A later ack alone -> irq_o=0.
- Three entries queued, pulse rst_i mid-ARMED -> level_o=0, alarm_en_o=0, late_o=0, fired_cnt_o=0 next cycle. No irq follows when the counter passes the old times. Repeat with async rst_an_i asserted between clock edges -> same result immediately.
